// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative MULT/MULTU/DIV/DIVU unit feeding the HI/LO registers
module mult_div_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] hi,
    output logic [width-1:0] lo,
    output logic             div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
    localparam int cw = $clog2(width + 1);

    state_t             state, state_nx;
    logic [1:0]         op_r;
    logic               sa, sb;
    logic [width-1:0]   ma, mb;
    logic [cw-1:0]      cnt;
    logic [2*width-1:0] acc;

    logic               a_neg, b_neg;
    logic [width-1:0]   a_mag, b_mag, a_raw;
    logic [width:0]     mul_sum, div_trial;
    logic [2*width-1:0] prod_fix;
    logic [width-1:0]   q_fix, r_fix;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (cnt == cw'(width - 1)) state_nx = FIN;
            FIN:     state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

    // op[0]=0 selects the signed variants
    assign a_neg = ~op[0] & a[width-1];
    assign b_neg = ~op[0] & b[width-1];
    assign a_mag = a_neg ? -a : a;
    assign b_mag = b_neg ? -b : b;
    assign a_raw = sa ? -ma : ma;

    // Multiply: add multiplicand into the upper half, then shift the whole accumulator right
    assign mul_sum   = {1'b0, acc[2*width-1:width]} + (mb[0] ? {1'b0, ma} : '0);
    // Divide: upper half is the partial remainder, lower half shifts dividend out and quotient in
    assign div_trial = acc[2*width-1:width-1] - {1'b0, mb};

    assign prod_fix = (~op_r[0] & (sa ^ sb)) ? -acc : acc;
    assign q_fix    = (~op_r[0] & (sa ^ sb)) ? -acc[width-1:0] : acc[width-1:0];
    assign r_fix    = (~op_r[0] & sa) ? -acc[2*width-1:width] : acc[2*width-1:width];

    always_ff @(posedge clk) begin
        if (reset) begin
            op_r        <= '0;
            sa          <= 1'b0;
            sb          <= 1'b0;
            ma          <= '0;
            mb          <= '0;
            cnt         <= '0;
            acc         <= '0;
            hi          <= '0;
            lo          <= '0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        op_r <= op;
                        sa   <= a_neg;
                        sb   <= b_neg;
                        ma   <= a_mag;
                        mb   <= b_mag;
                        cnt  <= '0;
                        acc  <= op[1] ? {{width{1'b0}}, a_mag} : '0;
                    end
                end
                RUN: begin
                    cnt <= cnt + 1'b1;
                    if (op_r[1]) begin
                        if (!div_trial[width])
                            acc <= {div_trial[width-1:0], acc[width-2:0], 1'b1};
                        else
                            acc <= {acc[2*width-2:0], 1'b0};
                    end else begin
                        acc <= {mul_sum, acc[width-1:1]};
                        mb  <= mb >> 1;
                    end
                end
                FIN: begin
                    done <= 1'b1;
                    if (op_r[1]) begin
                        if (mb == '0) begin
                            lo          <= '1;
                            hi          <= a_raw;
                            div_by_zero <= 1'b1;
                        end else begin
                            lo <= q_fix;
                            hi <= r_fix;
                        end
                    end else begin
                        hi <= prod_fix[2*width-1:width];
                        lo <= prod_fix[width-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
